// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage in-order core.
//
// Forwarding select for the two EX operands, load-use stall detection and
// a two-cycle IF/ID flush after a jump/jalr resolved in EX.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_rs, id_rt               ID instruction source registers
//   id_uses_rs, id_uses_rt     ID instruction actually reads that source
//   ex_rs, ex_rt, ex_rd        EX instruction sources and destination
//   ex_regwr, ex_memtoreg      EX writes a register / written value is load data
//   ex_redirect                jump/jalr resolved in EX this cycle
//   stall                      hold PC and IF/ID
//   idex_bubble                zero ID/EX control at the next edge
//   flush_ifid                 replace IF/ID with a NOP at the next edge
//   fwd_a, fwd_b               operand select: 00 regfile, 01 MEM ALU, 10 WB
//   stall_cnt, flush_cnt       saturating event counters (HAZARD_STATS_EN only)
//
// Build option: define HAZARD_STATS_EN to add the stall/flush counters.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] id_rs,
  input  logic [2:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [2:0] ex_rs,
  input  logic [2:0] ex_rt,
  input  logic [2:0] ex_rd,
  input  logic       ex_regwr,
  input  logic       ex_memtoreg,
  input  logic       ex_redirect,
  output logic       stall,
  output logic       idex_bubble,
  output logic       flush_ifid,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e     state_q, state_d;

  // Delayed copies of the EX destination info: MEM is 1 cycle old, WB 2.
  logic [2:0] mem_rd_q;
  logic       mem_regwr_q;
  logic       mem_memtoreg_q;
  logic [2:0] wb_rd_q;
  logic       wb_regwr_q;

  logic       load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StRun;
      mem_rd_q       <= 3'd0;
      mem_regwr_q    <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      wb_rd_q        <= 3'd0;
      wb_regwr_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_rd_q       <= ex_rd;
      mem_regwr_q    <= ex_regwr;
      mem_memtoreg_q <= ex_memtoreg;
      wb_rd_q        <= mem_rd_q;
      wb_regwr_q     <= mem_regwr_q;
    end
  end

  // Youngest producer wins. A load in MEM has no data yet, so it is skipped
  // and the older WB value is considered instead. r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [2:0] src,
                                         input logic [2:0] m_rd,
                                         input logic       m_wr,
                                         input logic       m_ld,
                                         input logic [2:0] w_rd,
                                         input logic       w_wr);
    logic [1:0] sel;
    sel = 2'b00;
    if (m_wr && !m_ld && (m_rd != 3'd0) && (m_rd == src)) begin
      sel = 2'b01;
    end else if (w_wr && (w_rd != 3'd0) && (w_rd == src)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  assign fwd_a = fwd_sel(ex_rs, mem_rd_q, mem_regwr_q, mem_memtoreg_q, wb_rd_q, wb_regwr_q);
  assign fwd_b = fwd_sel(ex_rt, mem_rd_q, mem_regwr_q, mem_memtoreg_q, wb_rd_q, wb_regwr_q);

  assign load_use = ex_memtoreg && ex_regwr && (ex_rd != 3'd0) &&
                    ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    idex_bubble = 1'b0;
    flush_ifid  = 1'b0;
    unique case (state_q)
      StRun: begin
        // Redirect beats load-use: the stalled consumer is on the wrong path.
        if (ex_redirect) begin
          flush_ifid  = 1'b1;
          idex_bubble = 1'b1;
          state_d     = StFlush;
        end else if (load_use) begin
          stall       = 1'b1;
          idex_bubble = 1'b1;
        end
      end
      StFlush: begin
        // Second flush cycle; redirects and stalls here are wrong-path.
        flush_ifid  = 1'b1;
        idex_bubble = 1'b1;
        state_d     = StRun;
      end
      default: state_d = StRun;
    endcase
    // Outputs are combinational from inputs, so quiet them explicitly in reset.
    if (!rst_n) begin
      stall       = 1'b0;
      idex_bubble = 1'b0;
      flush_ifid  = 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;
  logic        flush_start;

  assign flush_start = (state_q == StRun) && (state_d == StFlush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (flush_start && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic for hazard_ctrl,
// checked against a reference model built from a history of EX instructions.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] id_rs, id_rt;
  logic       id_uses_rs, id_uses_rt;
  logic [2:0] ex_rs, ex_rt, ex_rd;
  logic       ex_regwr, ex_memtoreg, ex_redirect;
  logic       stall, idex_bubble, flush_ifid;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  hazard_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_rs       (ex_rs),
    .ex_rt       (ex_rt),
    .ex_rd       (ex_rd),
    .ex_regwr    (ex_regwr),
    .ex_memtoreg (ex_memtoreg),
    .ex_redirect (ex_redirect),
    .stall       (stall),
    .idex_bubble (idex_bubble),
    .flush_ifid  (flush_ifid),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // hist_*[k] describes the instruction that was in EX k+1 cycles ago.
  int hist_rd [2] = '{0, 0};
  bit hist_wr [2] = '{0, 0};
  bit hist_ld [2] = '{0, 0};
  bit in_flush    = 1'b0;  // second cycle of a redirect flush
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;

  function automatic logic [1:0] m_fwd(input int src);
    for (int age = 0; age < 2; age++) begin
      if (hist_wr[age] && hist_rd[age] != 0 && hist_rd[age] == src) begin
        if (age == 1) return 2'b10;
        if (!hist_ld[age]) return 2'b01;  // load in MEM has no data yet
      end
    end
    return 2'b00;
  endfunction

  function automatic bit m_load_use();
    return ex_memtoreg && ex_regwr && ex_rd != 0 &&
           ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
  endfunction

  task automatic m_outs(output bit st, output bit bb, output bit fl,
                        output logic [1:0] fa, output logic [1:0] fb);
    st = 0; bb = 0; fl = 0; fa = 2'b00; fb = 2'b00;
    if (rst_n) begin
      fa = m_fwd(int'(ex_rs));
      fb = m_fwd(int'(ex_rt));
      if (in_flush || ex_redirect) begin
        fl = 1; bb = 1;
      end else if (m_load_use()) begin
        st = 1; bb = 1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_rd = '{0, 0}; hist_wr = '{0, 0}; hist_ld = '{0, 0};
      in_flush = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      bit st, bb, fl;
      logic [1:0] fa, fb;
      m_outs(st, bb, fl, fa, fb);
      if (st && m_stall_cnt < 65535) m_stall_cnt++;
      if (!in_flush && ex_redirect) begin
        if (m_flush_cnt < 65535) m_flush_cnt++;
        in_flush = 1;
      end else begin
        in_flush = 0;
      end
      hist_rd[1] = hist_rd[0]; hist_wr[1] = hist_wr[0]; hist_ld[1] = hist_ld[0];
      hist_rd[0] = int'(ex_rd); hist_wr[0] = ex_regwr; hist_ld[0] = ex_memtoreg;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit st, bb, fl;
    logic [1:0] fa, fb;
    #1;
    m_outs(st, bb, fl, fa, fb);
    check("stall", 32'(stall), 32'(st));
    check("idex_bubble", 32'(idex_bubble), 32'(bb));
    check("flush_ifid", 32'(flush_ifid), 32'(fl));
    check("fwd_a", 32'(fwd_a), 32'(fa));
    check("fwd_b", 32'(fwd_b), 32'(fb));
`ifdef HAZARD_STATS_EN
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush_cnt));
`endif
  endtask

  task automatic clr_in();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0;
    ex_regwr = 0; ex_memtoreg = 0; ex_redirect = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0; clr_in(); check_all();
    @(negedge clk); rst_n = 1; check_all();
  endtask

  initial begin
    rst_n = 0;
    clr_in();
    check_all();
    check("reset_stall", 32'(stall), 32'd0);
    do_reset();

    // ALU forward: MEM then WB.
    @(negedge clk); clr_in(); ex_rd = 3; ex_regwr = 1; check_all();
    @(negedge clk); clr_in(); ex_rs = 3; check_all();
    check("alu_fwd_a_mem", 32'(fwd_a), 32'd1);
    @(negedge clk); clr_in(); ex_rt = 3; check_all();
    check("alu_fwd_b_wb", 32'(fwd_b), 32'd2);

    // Double match: MEM wins.
    @(negedge clk); clr_in(); ex_rd = 5; ex_regwr = 1; check_all();
    @(negedge clk); clr_in(); ex_rd = 5; ex_regwr = 1; check_all();
    @(negedge clk); clr_in(); ex_rs = 5; check_all();
    check("double_match", 32'(fwd_a), 32'd1);

    // r0 is never a source.
    @(negedge clk); clr_in(); ex_rd = 0; ex_regwr = 1; check_all();
    @(negedge clk); clr_in(); check_all();
    check("r0_mem", 32'(fwd_a), 32'd0);
    @(negedge clk); clr_in(); check_all();
    check("r0_wb", 32'(fwd_a), 32'd0);

    // Load-use: one stall, bubble, then WB forward.
    @(negedge clk); clr_in(); ex_rd = 2; ex_regwr = 1; ex_memtoreg = 1;
    id_rs = 2; id_uses_rs = 1; check_all();
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_bubble", 32'(idex_bubble), 32'd1);
    @(negedge clk); clr_in(); id_rs = 2; id_uses_rs = 1; check_all();
    check("lu_release", 32'(stall), 32'd0);
    @(negedge clk); clr_in(); ex_rs = 2; check_all();
    check("lu_fwd_wb", 32'(fwd_a), 32'd2);

    // Redirect with load-use present; redirect during FLUSH ignored.
    do_reset();
    @(negedge clk); clr_in(); ex_rd = 1; ex_regwr = 1; ex_memtoreg = 1;
    id_rt = 1; id_uses_rt = 1; ex_redirect = 1; check_all();
    check("rd_stall0", 32'(stall), 32'd0);
    check("rd_flush0", 32'(flush_ifid), 32'd1);
    @(negedge clk); check_all();
    check("rd_stall1", 32'(stall), 32'd0);
    check("rd_flush1", 32'(flush_ifid), 32'd1);
    @(negedge clk); clr_in(); check_all();
    check("rd_flush_end", 32'(flush_ifid), 32'd0);
`ifdef HAZARD_STATS_EN
    check("rd_flush_cnt", 32'(flush_cnt), 32'd1);
    check("rd_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // Reset in the middle of FLUSH.
    @(negedge clk); clr_in(); ex_rd = 4; ex_regwr = 1; ex_redirect = 1; check_all();
    @(negedge clk); clr_in(); rst_n = 0; ex_rs = 4; check_all();
    check("rst_flush", 32'(flush_ifid), 32'd0);
    check("rst_bubble", 32'(idex_bubble), 32'd0);
    @(negedge clk); rst_n = 1; ex_rs = 4; check_all();
    check("rst_run", 32'(flush_ifid), 32'd0);
    check("rst_fwd", 32'(fwd_a), 32'd0);

    // Randomized traffic with occasional async resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 0;
        ex_redirect = 1'($urandom_range(0, 1));
        check_all();
        continue;
      end
      rst_n = 1;
      id_rs = 3'($urandom_range(0, 4));
      id_rt = 3'($urandom_range(0, 4));
      id_uses_rs = 1'($urandom_range(0, 1));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_rs = 3'($urandom_range(0, 4));
      ex_rt = 3'($urandom_range(0, 4));
      ex_rd = 3'($urandom_range(0, 4));
      ex_regwr = 1'($urandom_range(0, 3) != 0);
      ex_memtoreg = 1'($urandom_range(0, 2) == 0);
      ex_redirect = 1'($urandom_range(0, 7) == 0);
      check_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
